sys_top: RTL and testbench

Single-clock UART-controlled register/ALU subsystem. It receives command frames on a serial line and writes or reads a 16×8 register file. It runs ALU operations on two stored operands and returns results as serial frames. It is the top-level integration of UART RX, UART TX, command controller, register file and ALU.

---
 rtl/sys_top.sv | 260 ++++++++++++++++++++++++++
 tb/tb_sys_top.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sys_top.sv
// UART-controlled register file and ALU. Command frames arrive on UART_RX_IN.
// Read and ALU results are returned as even-parity frames on UART_TX_O.
module sys_top #(
  parameter int DATA_WIDTH   = 8,
  parameter int RF_ADDR      = 4,
  parameter int CLKS_PER_BIT = 32
) (
  input  logic REF_CLK,
  input  logic RST_N,
  input  logic UART_RX_IN,
  output logic UART_TX_O,
  output logic parity_error,
  output logic framing_error
);
  localparam int DW   = DATA_WIDTH;
  localparam int RW   = 2 * DATA_WIDTH;
  localparam int NREG = 1 << RF_ADDR;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(DATA_WIDTH + 3);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] STOP_IDX = BW'(DATA_WIDTH + 2);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUN, EXEC, TX_LO, TX_HI
  } state_t;

  // ---------------- receiver ----------------
  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  logic          rx_busy_q, rx_valid_q;
  logic [CW-1:0] rx_cnt_q;
  logic [BW-1:0] rx_bit_q;
  logic [DW:0]   rx_sh_q;
  logic [DW-1:0] rx_data_q;
  logic          parity_error_q, framing_error_q;

  always_ff @(posedge REF_CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_s1_q         <= 1'b1;
      rx_s2_q         <= 1'b1;
      rx_prev_q       <= 1'b1;
      rx_busy_q       <= 1'b0;
      rx_valid_q      <= 1'b0;
      rx_cnt_q        <= '0;
      rx_bit_q        <= '0;
      rx_sh_q         <= '0;
      rx_data_q       <= '0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      rx_s1_q    <= UART_RX_IN;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_valid_q <= 1'b0;
      if (!rx_busy_q) begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_busy_q <= 1'b1;
          rx_cnt_q  <= '0;
          rx_bit_q  <= '0;
        end
      end else if (rx_bit_q == '0) begin
        // Mid-start-bit check rejects short glitches.
        if (rx_cnt_q == HALF_END) begin
          rx_cnt_q <= '0;
          if (rx_s2_q) rx_busy_q <= 1'b0;
          else         rx_bit_q  <= BW'(1);
        end else begin
          rx_cnt_q <= rx_cnt_q + CW'(1);
        end
      end else if (rx_cnt_q == BIT_END) begin
        rx_cnt_q <= '0;
        rx_bit_q <= rx_bit_q + BW'(1);
        if (rx_bit_q == STOP_IDX) begin
          rx_busy_q       <= 1'b0;
          parity_error_q  <= ^rx_sh_q;
          framing_error_q <= !rx_s2_q;
          rx_valid_q      <= !(^rx_sh_q) && rx_s2_q;
          rx_data_q       <= rx_sh_q[DW-1:0];
        end else begin
          rx_sh_q <= {rx_s2_q, rx_sh_q[DW:1]};
        end
      end else begin
        rx_cnt_q <= rx_cnt_q + CW'(1);
      end
    end
  end

  assign parity_error  = parity_error_q;
  assign framing_error = framing_error_q;

  // ---------------- transmitter ----------------
  logic          tx_busy_q, tx_start, tx_done;
  logic [CW-1:0] tx_cnt_q;
  logic [BW-1:0] tx_bit_q;
  logic [DW+2:0] tx_sh_q;
  logic [DW-1:0] tx_byte;

  assign tx_done   = tx_busy_q && (tx_cnt_q == BIT_END) && (tx_bit_q == STOP_IDX);
  assign UART_TX_O = tx_sh_q[0];

  always_ff @(posedge REF_CLK or negedge RST_N) begin
    if (!RST_N) begin
      tx_busy_q <= 1'b0;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= '1;
    end else if (tx_start && (!tx_busy_q || tx_done)) begin
      // Reloading on the last stop-bit cycle gives gapless back-to-back frames.
      tx_busy_q <= 1'b1;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= {1'b1, ^tx_byte, tx_byte, 1'b0};
    end else if (tx_busy_q) begin
      if (tx_cnt_q == BIT_END) begin
        tx_cnt_q <= '0;
        if (tx_bit_q == STOP_IDX) begin
          tx_busy_q <= 1'b0;
        end else begin
          tx_bit_q <= tx_bit_q + BW'(1);
          tx_sh_q  <= {1'b1, tx_sh_q[DW+2:1]};
        end
      end else begin
        tx_cnt_q <= tx_cnt_q + CW'(1);
      end
    end
  end

  // ---------------- register file ----------------
  logic [DW-1:0]      rf_q [NREG];
  logic               rf_we;
  logic [RF_ADDR-1:0] rf_waddr;
  logic [DW-1:0]      rf_wdata;

  always_ff @(posedge REF_CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  // ---------------- ALU ----------------
  logic [3:0]    fun_q, fun_d;
  logic [DW-1:0] op_a, op_b, and_v, or_v, xor_v, nand_v, nor_v, xnor_v;
  logic [RW-1:0] a_w, b_w, alu_res;

  assign op_a   = rf_q[0];
  assign op_b   = rf_q[1];
  assign a_w    = RW'(op_a);
  assign b_w    = RW'(op_b);
  assign and_v  = op_a & op_b;
  assign or_v   = op_a | op_b;
  assign xor_v  = op_a ^ op_b;
  assign nand_v = ~and_v;
  assign nor_v  = ~or_v;
  assign xnor_v = ~xor_v;

  always_comb begin
    alu_res = '0;
    case (fun_q)
      4'h0: alu_res = a_w + b_w;
      4'h1: alu_res = a_w - b_w;
      4'h2: alu_res = a_w * b_w;
      4'h3: alu_res = (op_b == '0) ? '0 : a_w / b_w;
      4'h4: alu_res = RW'(and_v);
      4'h5: alu_res = RW'(or_v);
      4'h6: alu_res = RW'(nand_v);
      4'h7: alu_res = RW'(nor_v);
      4'h8: alu_res = RW'(xor_v);
      4'h9: alu_res = RW'(xnor_v);
      4'hA: alu_res = (op_a == op_b) ? RW'(1) : '0;
      4'hB: alu_res = (op_a > op_b)  ? RW'(2) : '0;
      4'hC: alu_res = (op_a < op_b)  ? RW'(3) : '0;
      4'hD: alu_res = a_w >> 1;
      4'hE: alu_res = a_w << 1;
      default: alu_res = '0;
    endcase
  end

  // ---------------- command controller ----------------
  state_t             state_q, state_d;
  logic [RF_ADDR-1:0] addr_q, addr_d;
  logic [DW-1:0]      res_hi_q, res_hi_d;

  always_ff @(posedge REF_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      fun_q    <= '0;
      res_hi_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      fun_q    <= fun_d;
      res_hi_q <= res_hi_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    fun_d    = fun_q;
    res_hi_d = res_hi_q;
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = rx_data_q;
    tx_start = 1'b0;
    tx_byte  = '0;
    case (state_q)
      IDLE: if (rx_valid_q) begin
        if      (rx_data_q == DW'(8'hAA)) state_d = WR_ADDR;
        else if (rx_data_q == DW'(8'hBB)) state_d = RD_ADDR;
        else if (rx_data_q == DW'(8'hCC)) state_d = ALU_A;
        else if (rx_data_q == DW'(8'hDD)) state_d = ALU_FUN;
      end
      WR_ADDR: if (rx_valid_q) begin
        addr_d  = rx_data_q[RF_ADDR-1:0];
        state_d = WR_DATA;
      end
      WR_DATA: if (rx_valid_q) begin
        rf_we    = 1'b1;
        rf_waddr = addr_q;
        state_d  = IDLE;
      end
      // A single-byte read reuses TX_HI as its only response state.
      RD_ADDR: if (rx_valid_q) begin
        tx_start = 1'b1;
        tx_byte  = rf_q[rx_data_q[RF_ADDR-1:0]];
        state_d  = TX_HI;
      end
      ALU_A: if (rx_valid_q) begin
        rf_we    = 1'b1;
        rf_waddr = RF_ADDR'(0);
        state_d  = ALU_B;
      end
      ALU_B: if (rx_valid_q) begin
        rf_we    = 1'b1;
        rf_waddr = RF_ADDR'(1);
        state_d  = ALU_FUN;
      end
      ALU_FUN: if (rx_valid_q) begin
        fun_d   = rx_data_q[3:0];
        state_d = EXEC;
      end
      EXEC: begin
        res_hi_d = alu_res[RW-1:DW];
        tx_start = 1'b1;
        tx_byte  = alu_res[DW-1:0];
        state_d  = TX_LO;
      end
      TX_LO: if (tx_done) begin
        tx_start = 1'b1;
        tx_byte  = res_hi_q;
        state_d  = TX_HI;
      end
      TX_HI: if (tx_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sys_top.sv
// Directed bench for sys_top: serial command frames in, response frames decoded
// and compared against hand-computed values.
module tb_sys_top;
  localparam int CLKS = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rx = 1'b1;
  logic tx, pe, fe;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   stop_cyc = 0;

  sys_top #(.DATA_WIDTH(8), .RF_ADDR(4), .CLKS_PER_BIT(CLKS)) dut (
    .REF_CLK      (clk),
    .RST_N        (rst_n),
    .UART_RX_IN   (rx),
    .UART_TX_O    (tx),
    .parity_error (pe),
    .framing_error(fe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    rx = 1'b0;
    tick(CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(CLKS);
    end
    rx = (^d) ^ bad_par;
    tick(CLKS);
    rx = !bad_stop;
    stop_cyc = cyc;
    tick(CLKS / 2 + 8);
    rx = 1'b1;
    $display("[TB] sent byte 0x%02h (bad_par=%0d bad_stop=%0d)", d, bad_par, bad_stop);
  endtask

  task automatic wait_tx_low(input int limit, output int t, output bit ok);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < limit; i++) begin
      if (tx === 1'b0) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
      tick(1);
    end
  endtask

  // ok is set only for a timely frame with start 0, even parity and stop 1.
  task automatic recv_frame(output logic [7:0] d, output int t, output bit ok);
    logic s0, p, sp;
    d = '0;
    wait_tx_low(40 * CLKS, t, ok);
    if (ok) begin
      tick(CLKS / 2);
      s0 = tx;
      for (int i = 0; i < 8; i++) begin
        tick(CLKS);
        d[i] = tx;
      end
      tick(CLKS);
      p = tx;
      tick(CLKS);
      sp = tx;
      ok = (s0 === 1'b0) && (p === ^d) && (sp === 1'b1);
      $display("[TB] received frame 0x%02h at cycle %0d (format ok=%0d)", d, t, ok);
    end
  endtask

  task automatic expect_resp1(input logic [7:0] last, input logic [7:0] exp, input string tag);
    logic [7:0] d;
    int t;
    bit ok;
    fork
      send_frame(last, 1'b0, 1'b0);
      recv_frame(d, t, ok);
    join
    check({tag, "_frame"}, 32'(ok), 32'd1);
    check({tag, "_data"}, 32'(d), 32'(exp));
    check({tag, "_latency"}, 32'((t > stop_cyc) && (t - stop_cyc <= 24)), 32'd1);
  endtask

  task automatic expect_resp2(input logic [7:0] last, input logic [15:0] exp, input string tag);
    logic [7:0] d0, d1;
    int t0, t1;
    bit ok0, ok1;
    fork
      send_frame(last, 1'b0, 1'b0);
      begin
        recv_frame(d0, t0, ok0);
        recv_frame(d1, t1, ok1);
      end
    join
    check({tag, "_frames"}, 32'(ok0 && ok1), 32'd1);
    check({tag, "_result"}, 32'({d1, d0}), 32'(exp));
    check({tag, "_gap"}, 32'(t1 - t0), 32'(11 * CLKS));
    check({tag, "_latency"}, 32'((t0 > stop_cyc) && (t0 - stop_cyc <= 24)), 32'd1);
  endtask

  initial begin
    int  t;
    bit  ok;
    logic before_rst, after_rst;

    #2 rst_n = 1'b0;
    tick(3);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_pe", 32'(pe), 32'd0);
    check("rst_fe", 32'(fe), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Write 0x55 to RF[4], read it back.
    send_frame(8'hAA, 1'b0, 1'b0);
    send_frame(8'h04, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0);
    send_frame(8'hBB, 1'b0, 1'b0);
    expect_resp1(8'h04, 8'h55, "rd4");
    check("rd4_pe", 32'(pe), 32'd0);
    check("rd4_fe", 32'(fe), 32'd0);

    // ALU with operands: 0xAA + 0xBB.
    send_frame(8'hCC, 1'b0, 1'b0);
    send_frame(8'hAA, 1'b0, 1'b0);
    send_frame(8'hBB, 1'b0, 1'b0);
    expect_resp2(8'h00, 16'h0165, "add");
    send_frame(8'hBB, 1'b0, 1'b0);
    expect_resp1(8'h00, 8'hAA, "rf0");
    send_frame(8'hBB, 1'b0, 1'b0);
    expect_resp1(8'h01, 8'hBB, "rf1");

    // ALU on stored operands.
    send_frame(8'hDD, 1'b0, 1'b0);
    expect_resp2(8'h02, 16'h7C2E, "mul");
    send_frame(8'hDD, 1'b0, 1'b0);
    expect_resp2(8'h03, 16'h0000, "div");
    send_frame(8'hDD, 1'b0, 1'b0);
    expect_resp2(8'h0C, 16'h0003, "lt");

    // Parity error drops the byte; next good frame clears the flag.
    send_frame(8'hAA, 1'b1, 1'b0);
    check("par_pe", 32'(pe), 32'd1);
    check("par_fe", 32'(fe), 32'd0);
    send_frame(8'hBB, 1'b0, 1'b0);
    expect_resp1(8'h04, 8'h55, "par_rd");
    check("par_rd_pe", 32'(pe), 32'd0);

    // Framing error, then a one-cycle glitch on the idle line.
    send_frame(8'hAA, 1'b0, 1'b1);
    check("frm_fe", 32'(fe), 32'd1);
    check("frm_pe", 32'(pe), 32'd0);
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    wait_tx_low(12 * CLKS, t, ok);
    check("glitch_no_tx", 32'(ok), 32'd0);
    check("glitch_fe", 32'(fe), 32'd1);
    check("glitch_pe", 32'(pe), 32'd0);
    send_frame(8'hBB, 1'b0, 1'b0);
    expect_resp1(8'h04, 8'h55, "frm_rd");
    check("frm_rd_fe", 32'(fe), 32'd0);

    // Reset during the low-byte response frame (0x03: data bit 4 is 0).
    send_frame(8'hDD, 1'b0, 1'b0);
    before_rst = 1'b1;
    after_rst  = 1'b0;
    fork
      send_frame(8'h0C, 1'b0, 1'b0);
      begin
        wait_tx_low(40 * CLKS, t, ok);
        tick(5 * CLKS);
        before_rst = tx;
        #2 rst_n = 1'b0;
        #1 after_rst = tx;
      end
    join
    check("rst_resp_seen", 32'(ok), 32'd1);
    check("rst_tx_before", 32'(before_rst), 32'd0);
    check("rst_tx_async", 32'(after_rst), 32'd1);
    tick(3);
    rst_n = 1'b1;
    tick(2);
    check("rst2_tx", 32'(tx), 32'd1);
    check("rst2_pe", 32'(pe), 32'd0);
    check("rst2_fe", 32'(fe), 32'd0);
    send_frame(8'hBB, 1'b0, 1'b0);
    expect_resp1(8'h04, 8'h00, "rst_rd");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
